// File: rtl/counter_pkg.sv
// counter_pkg: shared helpers for the up/down counter and its prescaler.
//   clog2()        ceil(log2(n)), used to size the prescaler phase register
//   cnt_cfg_ok()   parameter sanity check for updown_counter
//   pre_width()    prescaler register width (never zero)
package counter_pkg;

  localparam int MAX_WIDTH    = 16;
  localparam int MAX_PRESCALE = 65535;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    return r;
  endfunction

  // A one-cycle prescaler still needs a 1-bit register to keep ports legal.
  function automatic int pre_width(input int prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

  function automatic bit cnt_cfg_ok(input int width, input int max_val,
                                    input int prescale);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (max_val >= 0) && (64'(max_val) < (64'd1 << width)) &&
           (prescale >= 1) && (prescale <= MAX_PRESCALE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a step strobe every PRESCALE enabled cycles.
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears the phase
//   en    in   advances the phase; low holds it
//   clr   in   clears the phase (parallel load in the parent)
//   tick  out  combinational: en && phase == PRESCALE-1
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = pre_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      if (pre == LAST) pre <= '0;
      else             pre <= pre + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with prescaler, load,
// wrap/saturate mode and a wrap pulse for cascading.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   count enable (also gates the prescaler)
//   up        in   1 = increment, 0 = decrement
//   sat       in   1 = saturate at limits, 0 = wrap
//   load      in   parallel load strobe (wins over a step)
//   load_val  in   value to load, clamped to MAX_VAL
//   count     out  registered count
//   wrap      out  registered one-cycle pulse on a wrapping step
//   at_limit  out  combinational: count sits at the limit for direction up
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  localparam bit CFG_OK = cnt_cfg_ok(WIDTH, MAX_VAL, PRESCALE);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("updown_counter: bad WIDTH/MAX_VAL/PRESCALE");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MV = WIDTH'(MAX_VAL);

  logic             tick;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;
  logic             wrap_step;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign at_max   = (count == MV);
  assign at_zero  = (count == '0);
  assign at_limit = (up && at_max) || (!up && at_zero);

  assign load_clamped = (load_val > MV) ? MV : load_val;

  // Limit is tested before +/-1, so the adder never needs a carry bit.
  always_comb begin
    count_step = count;
    wrap_step  = 1'b0;
    if (up) begin
      if (!at_max)   count_step = count + WIDTH'(1);
      else if (!sat) begin
        count_step = '0;
        wrap_step  = 1'b1;
      end
    end else begin
      if (!at_zero)  count_step = count - WIDTH'(1);
      else if (!sat) begin
        count_step = MV;
        wrap_step  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (tick) begin
      count <= count_step;
      wrap  <= wrap_step;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count_a, count_b;
  logic       wrap_a, wrap_b, lim_a, lim_b;

  always #5 clk = ~clk;

  // A: full 4-bit range, step every cycle. B: modulus 10, step every 3rd.
  updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(count_a), .wrap(wrap_a), .at_limit(lim_a));

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(count_b), .wrap(wrap_b), .at_limit(lim_b));

  typedef struct {
    int count;
    bit wrap;
    bit lim;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int   compared = 0, mismatched = 0;
  bit   done = 0;

  // reference state: count value and enabled-cycle phase
  int m_cnt[2], m_pre[2];
  int m_max[2] = '{15, 9};
  int m_psc[2] = '{1, 3};

  function automatic exp_t model(input int i, input bit r, l, e, u, s,
                                 input int lv);
    exp_t x;
    int   modn;
    modn   = m_max[i] + 1;
    x.wrap = 0;
    if (r) begin
      m_cnt[i] = 0;
      m_pre[i] = 0;
    end else if (l) begin
      m_cnt[i] = (lv > m_max[i]) ? m_max[i] : lv;
      m_pre[i] = 0;
    end else if (e) begin
      m_pre[i] = (m_pre[i] + 1) % m_psc[i];
      if (m_pre[i] == 0) begin
        // a step: edge of the range either saturates or wraps modulo MAX+1
        if (u && m_cnt[i] == m_max[i] || !u && m_cnt[i] == 0) begin
          if (!s) begin
            m_cnt[i] = (m_cnt[i] + (u ? 1 : modn - 1)) % modn;
            x.wrap   = 1;
          end
        end else begin
          m_cnt[i] = m_cnt[i] + (u ? 1 : -1);
        end
      end
    end
    x.count = m_cnt[i];
    x.lim   = u ? (m_cnt[i] == m_max[i]) : (m_cnt[i] == 0);
    return x;
  endfunction

  task automatic cyc(input bit r, l, e, u, s, input logic [3:0] lv);
    @(negedge clk);
    rst = r; load = l; en = e; up = u; sat = s; load_val = lv;
    q_a.push_back(model(0, r, l, e, u, s, int'(lv)));
    q_b.push_back(model(1, r, l, e, u, s, int'(lv)));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: the counter presents a result every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a.count", int'(count_a), e.count);
        chk("a.wrap", int'(wrap_a), int'(e.wrap));
        chk("a.at_limit", int'(lim_a), int'(e.lim));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b.count", int'(count_b), e.count);
        chk("b.wrap", int'(wrap_b), int'(e.wrap));
        chk("b.at_limit", int'(lim_b), int'(e.lim));
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: stimulus did not complete, expected completion");
      $fatal(1, "timeout");
    end
  end

  initial begin
    // reset then count up with wrap
    repeat (2) cyc(1, 0, 1, 1, 0, 4'd0);
    repeat (20) cyc(0, 0, 1, 1, 0, 4'd0);
    // saturate high, then reverse down into saturation at zero
    repeat (60) cyc(0, 0, 1, 1, 1, 4'd0);
    repeat (60) cyc(0, 0, 1, 0, 1, 4'd0);
    // down wrap from zero
    cyc(0, 1, 0, 0, 0, 4'd0);
    repeat (15) cyc(0, 0, 1, 0, 0, 4'd0);
    // enable dropped mid prescale period
    cyc(0, 1, 0, 1, 0, 4'd2);
    repeat (2) cyc(0, 0, 1, 1, 0, 4'd0);
    repeat (4) cyc(0, 0, 0, 1, 0, 4'd0);
    repeat (7) cyc(0, 0, 1, 1, 0, 4'd0);
    // load clamp, and load landing on step / wrap cycles
    cyc(0, 1, 1, 1, 0, 4'd12);
    repeat (3) cyc(0, 0, 1, 1, 0, 4'd0);
    cyc(0, 1, 0, 1, 0, 4'd15);
    cyc(0, 1, 1, 1, 0, 4'd5);
    cyc(0, 1, 0, 1, 0, 4'd9);
    repeat (2) cyc(0, 0, 1, 1, 0, 4'd0);
    cyc(0, 1, 1, 1, 0, 4'd3);
    repeat (2) cyc(0, 0, 1, 1, 0, 4'd0);
    // reset mid-count, then resume
    cyc(0, 1, 0, 1, 0, 4'd7);
    cyc(0, 0, 1, 1, 0, 4'd0);
    cyc(1, 0, 1, 1, 0, 4'd0);
    repeat (6) cyc(0, 0, 1, 1, 0, 4'd0);
    // random soak
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0),
          ($urandom_range(0, 2) == 0), 4'($urandom));
    repeat (3) @(negedge clk);
    chk("queue_drained", q_a.size() + q_b.size(), 0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter replacing the fixed 4-bit free-running LED counter. It adds:
- configurable width, modulus and prescale;
- runtime direction, enable, parallel load and wrap/saturate mode;
- a wrap pulse for chaining.

It sits between board I/O (switches, buttons) and the LED bank. It is also reused as a cascadable timebase.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..16)
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL
- PRESCALE, 1, enabled cycles per count step (1..65535); 1 means a step every enabled cycle

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; low freezes count and prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  mode: 1 = saturate at limits, 0 = wrap
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count, registered (drives LEDs)
- wrap  out  1  registered one-cycle pulse on the edge where count wraps
- at_limit  out  1  combinational: (up && count==MAX_VAL) || (!up && count==0)

## Operation
- Reset values: count=0, wrap=0, prescaler=0. at_limit then follows count and up.
- Priority per edge is rst > load > step.
- Load:
  - count <= min(load_val, MAX_VAL), so out-of-range load values clamp to MAX_VAL.
  - prescaler cleared, wrap=0.
  - Load acts regardless of en.
- Prescaler pre (0..PRESCALE-1):
  - advances only when en=1 and load=0;
  - a step fires when en=1 and pre==PRESCALE-1, after which pre returns to 0;
  - PRESCALE=1 means every enabled cycle is a step.
- Step, counting up:
  - count<MAX_VAL gives count+1.
  - At MAX_VAL with sat=0: count goes to 0 and wrap=1.
  - At MAX_VAL with sat=1: count holds and wrap=0.
- Step, counting down:
  - count>0 gives count-1.
  - At 0 with sat=0: count goes to MAX_VAL and wrap=1.
  - At 0 with sat=1: count holds and wrap=0.
- wrap is 0 on every edge that is not a wrapping step.
- up, sat and en are sampled every edge; changes take effect on the next step with no pipeline flush.
- All arithmetic is WIDTH bits. The MAX_VAL comparison is done before the increment, so no overflow bit is needed.

## Timing
- Count latency: one cycle from the sampled edge to the count change.
- Load latency: one cycle.
- wrap is coincident with the count update that wrapped and lasts exactly one cycle. With PRESCALE=1 and a continuous wrap condition it can assert on consecutive steps only if MAX_VAL=0.
- Cascading: wiring an upstream wrap to a downstream en gives a correct multi-digit counter.
- Reset mid-count: count=0 and pre=0 on the next edge, and any pending wrap is suppressed.
- load and step in the same cycle: load wins and the step is lost.
- MAX_VAL=0 is legal: count stays 0; with sat=0, wrap pulses on every step.

## Structure
- Shared package counter_pkg:
  - function clog2 used for the prescaler width;
  - localparam checks: MAX_VAL < 2**WIDTH, PRESCALE >= 1.
- Sub-module tick_gen (PRESCALE parameter):
  - inputs clk, rst, en, clr;
  - output tick = en && pre==PRESCALE-1.
  - updown_counter instantiates it with clr = load.
- Top-level count register, limit compare, wrap register and at_limit logic live in updown_counter.

## Test plan
- Reset, then wrap up (WIDTH=4, PRESCALE=1, en=1, up=1, sat=0, rst for 2 cycles): count=0; after 15 cycles count=15 and at_limit=1; next edge count=0 and wrap=1 for one cycle.
- Saturate and reverse (sat=1, up=1): reach 15; count holds at 15 for 5 cycles with wrap=0. Switch up=0: count goes 14, 13, ... down to 0 and holds at 0.
- Down wrap with modulus (MAX_VAL=9, up=0, sat=0, from count=0): next step gives count=9 and wrap=1. Later count=3 and at_limit=0.
- Prescale and enable (PRESCALE=3):
  - count steps every 3rd enabled cycle;
  - en dropped for 4 cycles mid-period: prescaler resumes at its held phase.
- Load clamp and priority:
  - load_val=12 with MAX_VAL=9 gives count=9;
  - load asserted on a step cycle: loaded value wins and wrap=0.
- Reset mid-operation: rst asserted while count=7 and pre=1 gives count=0 and wrap=0; the next step occurs PRESCALE enabled cycles after rst drops.
